frac_clken_gen: RTL and testbench
=================================

# frac_clken_gen

Multi-channel fractional clock-enable generator driven from the system PLL output clock. Each channel runs a phase accumulator that emits one-cycle enable pulses at a programmable fraction of the master clock, for example CPU/VDP/PSG enables from 53.693175 MHz. The channels can be retuned at run time without stopping the other channels. A settle/lock state machine provides a `locked` status compatible with the PLL's own `locked` output, so downstream logic gates on one signal.

## Interface
- `CHANNELS`, 2, number of independent enable outputs (1–8).
- `ACC_W`, 32, accumulator/increment width in bits (8–32).
- `LOCK_CYCLES`, 16, clock edges in SETTLE before `locked` asserts (≥1).

- `refclk`  in  1  master clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `run`  in  1  level; 1 = generate enables, 0 = hold in IDLE.
- `cfg_we`  in  1  one-cycle write strobe for channel config.
- `cfg_ch`  in  3  target channel index.
- `cfg_inc`  in  ACC_W  per-cycle increment; enable rate = inc / 2^ACC_W × f(refclk).
- `cfg_phase`  in  ACC_W  accumulator preload value applied on IDLE.
- `ce_out`  out  CHANNELS  registered enable pulses, one bit per channel.
- `locked`  out  1  registered; 1 = enables stable for ≥ LOCK_CYCLES edges since the last start or retune.

## Operation
- Reset state: every `inc`, `phase`, and `acc` register = 0; `ce_out` = 0; `locked` = 0; FSM = IDLE.
- FSM has three states: IDLE, SETTLE, LOCKED.
  - IDLE: each `acc[i]` loads `phase[i]` every edge. `ce_out` = 0, `locked` = 0. On `run`=1, go to SETTLE with `settle_cnt` = 0.
  - SETTLE: accumulate. `settle_cnt` increments each edge. On the edge where `settle_cnt` == LOCK_CYCLES-1 with no write, go to LOCKED.
  - LOCKED: accumulate. `locked` = 1.
  - From SETTLE or LOCKED, `run`=0 returns to IDLE on the next edge.
- Accumulate: `{carry, acc[i]} = acc[i] + inc[i]`, computed at ACC_W+1 bits. `acc[i]` takes the low ACC_W bits, so it wraps modulo 2^ACC_W. `ce_out[i]` is registered from `carry`.
- Config write, `cfg_we`=1 and `cfg_ch` < CHANNELS:
  - `inc[cfg_ch]` and `phase[cfg_ch]` update on that edge. The new `inc` is used from the next edge.
  - `acc` is not disturbed, so the retune is glitch-free.
  - `cfg_ch` ≥ CHANNELS: the write is ignored and the FSM is unaffected.
- A write accepted in SETTLE or LOCKED sends the FSM to SETTLE with `settle_cnt` = 0. `locked` falls on that edge.
- A write accepted in IDLE updates registers only. The new phase is loaded into `acc` on the following edge.
- Simultaneous write and `run` fall: the write takes effect and the FSM goes to IDLE.
- `inc` = 0 means the channel never pulses. `inc` ≥ 2^(ACC_W-1) gives pulses on alternating or consecutive cycles. `inc` = 2^ACC_W − 1 pulses on every edge except one per 2^ACC_W.

## Timing
- Let edge k be the first edge sampling `run`=1 in IDLE. On edge k, `acc` keeps `phase`; no add is performed.
- Adds begin at edge k+1.
- `ce_out[i]` is high for exactly one cycle after each edge that produced a carry. The pipeline latency from carry to output is 1 register.
- `locked` rises after edge k+LOCK_CYCLES, provided no write is accepted in between.
- `run` fall sampled at edge m: `ce_out` = 0 and `locked` = 0 after edge m.
- Asserting `rst` mid-operation clears all outputs immediately, without waiting for a clock edge.

## Structure
- Shared package `clken_pkg` holds:
  - the FSM state enum (IDLE, SETTLE, LOCKED);
  - the `MAX_CHANNELS` = 8 constant;
  - the `CFG_CH_W` = 3 constant.
- Sub-module `frac_clken_ch` contains one channel's `inc`/`phase`/`acc` registers, its adder, and its `ce` flop. It is instantiated CHANNELS times by a generate loop.
- The top level holds the FSM, `settle_cnt` ($clog2(LOCK_CYCLES)+1 bits), and config address decode.

## Test plan
- Reset, then `run`=1 with all `inc` = 0 → `ce_out` stays 0; `locked` rises LOCK_CYCLES edges after the start edge (16 with default).
- Ch0 `inc` = 2^31, `phase` = 0, ACC_W=32 → first pulse after edge k+2, then every 2 cycles; exactly 50 pulses in 100 cycles.
- Ch1 `inc` = 0x5555_5556, `phase` = 0xAAAA_AAAA → first pulse after edge k+1; average period 3 cycles; 333 or 334 pulses in 1000 cycles.
- While LOCKED, write ch0 `inc` 2^31→2^30 → `locked` drops the same edge; ch1 pulse pattern unchanged; ch0 period 4 from the next carry; `locked` re-asserts 16 edges later.
- Write with `cfg_ch` = 5 and CHANNELS=2 → no register change; `locked` stays 1.
- `rst` pulse mid-run and `run` fall coincident with `cfg_we` → all outputs 0 asynchronously and in IDLE respectively; the written `inc` persists after the `run` fall and is 0 after `rst`.

Source files
------------

// File: rtl/clken_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
package clken_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StLocked
  } clken_state_e;

  localparam int unsigned MAX_CHANNELS = 8;
  localparam int unsigned CFG_CH_W     = 3;

endpackage

// File: rtl/frac_clken_ch.sv
// One enable channel: config registers, phase accumulator and registered carry pulse.
module frac_clken_ch #(
  parameter int unsigned ACC_W = 32
) (
  input  logic             i_refclk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic             i_load,
  input  logic             i_add,
  input  logic [ACC_W-1:0] i_inc,
  input  logic [ACC_W-1:0] i_phase,
  output logic             o_ce
);

  logic [ACC_W-1:0] r_inc;
  logic [ACC_W-1:0] r_phase;
  logic [ACC_W-1:0] r_acc;
  logic             r_ce;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

  // A write changes inc/phase only; acc keeps running so a retune never glitches the output.
  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_inc   <= '0;
      r_phase <= '0;
      r_acc   <= '0;
      r_ce    <= 1'b0;
    end else begin
      if (i_we) begin
        r_inc   <= i_inc;
        r_phase <= i_phase;
      end
      if (i_load) begin
        r_acc <= r_phase;
      end else if (i_add) begin
        r_acc <= w_sum[ACC_W-1:0];
      end
      r_ce <= i_add & w_sum[ACC_W];
    end
  end

  assign o_ce = r_ce;

endmodule

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator with a settle/lock status FSM.
module frac_clken_gen
  import clken_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                i_refclk,
  input  logic                i_rst,
  input  logic                i_run,
  input  logic                i_cfg_we,
  input  logic [CFG_CH_W-1:0] i_cfg_ch,
  input  logic [ACC_W-1:0]    i_cfg_inc,
  input  logic [ACC_W-1:0]    i_cfg_phase,
  output logic [CHANNELS-1:0] o_ce_out,
  output logic                o_locked
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  clken_state_e     r_state;
  clken_state_e     w_state_d;
  logic [CNT_W-1:0] r_settle_cnt;
  logic [CNT_W-1:0] w_settle_cnt_d;
  logic             r_locked;
  logic             w_cfg_hit;
  logic             w_idle;
  logic             w_add;

  assign w_cfg_hit = i_cfg_we && (32'(i_cfg_ch) < CHANNELS);
  assign w_idle    = (r_state == StIdle);
  // The edge that samples run=0 already stops accumulation and zeroes the enables.
  assign w_add     = !w_idle && i_run;

  always_comb begin
    w_state_d      = r_state;
    w_settle_cnt_d = r_settle_cnt;
    unique case (r_state)
      StIdle: begin
        w_settle_cnt_d = '0;
        if (i_run) begin
          w_state_d = StSettle;
        end
      end
      StSettle, StLocked: begin
        if (!i_run) begin
          w_state_d = StIdle;
        end else if (w_cfg_hit) begin
          w_state_d      = StSettle;
          w_settle_cnt_d = '0;
        end else if (r_state == StSettle) begin
          w_settle_cnt_d = r_settle_cnt + 1'b1;
          if (r_settle_cnt == CNT_LAST) begin
            w_state_d = StLocked;
          end
        end
      end
      default: begin
        w_state_d      = StIdle;
        w_settle_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_settle_cnt <= '0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_settle_cnt <= w_settle_cnt_d;
      r_locked     <= (w_state_d == StLocked);
    end
  end

  assign o_locked = r_locked;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic w_ch_we;
    assign w_ch_we = w_cfg_hit && (i_cfg_ch == CFG_CH_W'(g));

    frac_clken_ch #(
      .ACC_W(ACC_W)
    ) u_ch (
      .i_refclk(i_refclk),
      .i_rst   (i_rst),
      .i_we    (w_ch_we),
      .i_load  (w_idle),
      .i_add   (w_add),
      .i_inc   (i_cfg_inc),
      .i_phase (i_cfg_phase),
      .o_ce    (o_ce_out[g])
    );
  end

endmodule

// File: tb/tb_frac_clken_gen.sv
// Self-checking bench for frac_clken_gen against a cycle-level arithmetic reference model.
module tb_frac_clken_gen;

  localparam int unsigned CH   = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned LOCK = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          we;
  logic [2:0]    cch;
  logic [AW-1:0] cinc;
  logic [AW-1:0] cphase;
  logic [CH-1:0] ce_out;
  logic          locked;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: plain integers, "running" flag and edges since last start/retune.
  logic [AW-1:0] m_inc   [CH];
  logic [AW-1:0] m_phase [CH];
  logic [AW-1:0] m_acc   [CH];
  bit            m_running;
  int            m_stable;
  logic [CH-1:0] exp_ce;
  logic          exp_locked;
  int            pulses [CH];

  frac_clken_gen #(
    .CHANNELS   (CH),
    .ACC_W      (AW),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .i_refclk   (clk),
    .i_rst      (rst),
    .i_run      (run),
    .i_cfg_we   (we),
    .i_cfg_ch   (cch),
    .i_cfg_inc  (cinc),
    .i_cfg_phase(cphase),
    .o_ce_out   (ce_out),
    .o_locked   (locked)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_inc[i] = '0; m_phase[i] = '0; m_acc[i] = '0;
    end
    m_running = 0; m_stable = 0; exp_ce = '0; exp_locked = 0;
  endtask

  task automatic model_edge();
    bit        hit;
    bit [AW:0] sum;
    hit    = we && (int'(cch) < CH);
    exp_ce = '0;
    if (!m_running) begin
      for (int i = 0; i < CH; i++) m_acc[i] = m_phase[i];
      if (run) begin m_running = 1; m_stable = 0; end
    end else if (!run) begin
      m_running = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        sum       = {1'b0, m_acc[i]} + {1'b0, m_inc[i]};
        exp_ce[i] = sum[AW];
        m_acc[i]  = sum[AW-1:0];
      end
      if (hit) m_stable = 0;
      else if (m_stable < LOCK) m_stable++;
    end
    if (hit) begin m_inc[cch] = cinc; m_phase[cch] = cphase; end
    exp_locked = m_running && (m_stable >= LOCK);
  endtask

  task automatic check_outs(string tag, logic [CH-1:0] e_ce, logic e_lk);
    n_cmp++;
    assert (ce_out === e_ce) else begin
      n_err++;
      $error("FAIL %s ce_out got %b expected %b", tag, ce_out, e_ce);
    end
    n_cmp++;
    assert (locked === e_lk) else begin
      n_err++;
      $error("FAIL %s locked got %b expected %b", tag, locked, e_lk);
    end
  endtask

  task automatic step(string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outs(tag, exp_ce, exp_locked);
    for (int i = 0; i < CH; i++) if (ce_out[i] === 1'b1) pulses[i]++;
    we = 0;
  endtask

  task automatic write(input int ch, input logic [AW-1:0] inc, input logic [AW-1:0] ph);
    we = 1; cch = 3'(ch); cinc = inc; cphase = ph;
  endtask

  task automatic async_reset(string tag);
    #2 rst = 1;
    #1;
    model_reset();
    check_outs(tag, '0, 1'b0);
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    rst = 1; run = 0; we = 0; cch = '0; cinc = '0; cphase = '0;
    model_reset();
    #2;
    check_outs("reset", '0, 1'b0);
    @(posedge clk);
    #1 rst = 0;

    // All increments zero: no pulses, lock after LOCK edges past the start edge.
    run = 1;
    for (int j = 0; j < 20; j++) begin
      step("zero_inc");
      if (j == LOCK - 1) begin
        n_cmp++;
        assert (locked === 1'b0) else begin
          n_err++; $error("FAIL lock_early locked got %b expected 0", locked);
        end
      end
      if (j == LOCK) begin
        n_cmp++;
        assert (locked === 1'b1) else begin
          n_err++; $error("FAIL lock_edge locked got %b expected 1", locked);
        end
      end
    end

    run = 0;
    step("stop");
    write(0, 32'h8000_0000, 32'h0);
    step("cfg0_idle");
    write(1, 32'h5555_5556, 32'hAAAA_AAAA);
    step("cfg1_idle");
    step("idle_load");

    run = 1;
    step("start");
    pulses[0] = 0; pulses[1] = 0;
    for (int j = 0; j < 100; j++) step("half_rate");
    n_cmp++;
    assert (pulses[0] == 50) else begin
      n_err++; $error("FAIL ch0_count got %0d expected 50", pulses[0]);
    end
    for (int j = 100; j < 1000; j++) step("third_rate");
    n_cmp++;
    assert (pulses[1] == 333 || pulses[1] == 334) else begin
      n_err++; $error("FAIL ch1_count got %0d expected 333..334", pulses[1]);
    end

    // Retune ch0 while locked.
    write(0, 32'h4000_0000, 32'h0);
    step("retune");
    n_cmp++;
    assert (locked === 1'b0) else begin
      n_err++; $error("FAIL retune_unlock locked got %b expected 0", locked);
    end
    for (int j = 0; j < 24; j++) step("retuned");

    write(5, 32'hFFFF_FFFF, 32'h1234_5678);
    step("bad_ch");
    n_cmp++;
    assert (locked === 1'b1) else begin
      n_err++; $error("FAIL bad_ch_locked locked got %b expected 1", locked);
    end
    for (int j = 0; j < 8; j++) step("after_bad_ch");

    // Run fall with a simultaneous write, then restart with the new increment.
    run = 0;
    write(1, 32'hFFFF_FFFF, 32'h0000_0010);
    step("fall_write");
    step("idle2");
    run = 1;
    for (int j = 0; j < 30; j++) step("restart");

    async_reset("rst_mid");
    for (int j = 0; j < 20; j++) step("post_rst");

    // Randomized traffic.
    for (int j = 0; j < 400; j++) begin
      run = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) begin
        write(int'($urandom_range(0, 7)), $urandom, $urandom);
        if ($urandom_range(0, 1) == 0) cinc = {1'b1, cinc[AW-2:0]};
      end
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

endmodule
